// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the int pipeline and a buffered FPU onto the register-file write port.
// Optional WB_PENDING_MASK_EN adds pend_f, a per-float-register "result still buffered" mask.
module wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             int_valid,
    input  logic [4:0]       int_rd,
    input  logic [31:0]      int_data,
    input  logic             int_float,
    input  logic             fpu_valid,
    output logic             fpu_ready,
    input  logic [4:0]       fpu_rd,
    input  logic [31:0]      fpu_data,
    output logic             stall_int,
    output logic [4:0]       writeReg,
    output logic [31:0]      writeData,
    output logic             regWrite,
    output logic             float,
    output logic [PTR_W:0]   fifo_count
`ifdef WB_PENDING_MASK_EN
    ,
    output logic [31:0]      pend_f
`endif
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       rd_mem_q   [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic             stall_q, stall_d;
    logic             we_q, we_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             fl_q, fl_d;

    logic empty, full, push, store, int_go, pop;
    logic [4:0] head_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign head_rd = rd_mem_q[rd_ptr_q];

    // Ready comes from the registered count: a same-cycle pop never frees a slot.
    assign fpu_ready = !reset && !full;
    assign push      = fpu_valid && fpu_ready;
    assign store     = push && (fpu_rd != 5'd0);
    assign int_go    = int_valid && !stall_q && (int_rd != 5'd0);
    assign pop       = !int_go && !empty;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (store && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !store) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        wait_d  = '0;
        stall_d = 1'b0;
        if (!empty && !pop) begin
            if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                stall_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        fl_d    = fl_q;
        if (int_go) begin
            we_d    = 1'b1;
            wreg_d  = int_rd;
            wdata_d = int_data;
            fl_d    = int_float;
        end else if (pop) begin
            we_d    = 1'b1;
            wreg_d  = head_rd;
            wdata_d = data_mem_q[rd_ptr_q];
            fl_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wait_q   <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            fl_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            fl_q     <= fl_d;
        end
    end

    // Storage needs no reset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            rd_mem_q[wr_ptr_q]   <= fpu_rd;
            data_mem_q[wr_ptr_q] <= fpu_data;
        end
    end

    assign stall_int  = stall_q;
    assign regWrite   = we_q;
    assign writeReg   = wreg_q;
    assign writeData  = wdata_q;
    assign float      = fl_q;
    assign fifo_count = count_q;

`ifdef WB_PENDING_MASK_EN
    logic [PTR_W:0] pend_q [32];
    logic [PTR_W:0] pend_d [32];

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pend_d[r] = pend_q[r];
            if (r != 0) begin
                if (store && fpu_rd == 5'(r) && !(pop && head_rd == 5'(r))) begin
                    pend_d[r] = pend_q[r] + 1'b1;
                end else if (pop && head_rd == 5'(r) && !(store && fpu_rd == 5'(r))) begin
                    pend_d[r] = pend_q[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            if (reset) begin
                pend_q[r] <= '0;
            end else begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

    always_comb begin
        pend_f = '0;
        for (int r = 1; r < 32; r++) begin
            pend_f[r] = (pend_q[r] != '0);
        end
    end
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter directly upstream of the 32x32 integer/float register file. It drives the file's single write port: writeReg, writeData, regWrite and float.
- Merges two result sources:
  - the in-order integer pipeline (no backpressure, priority);
  - a multi-cycle FPU (valid/ready), whose results are buffered in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so FPU results always drain.

Parameters:
- DEPTH, 4: FPU result FIFO entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).
- MAX_WAIT, 8: consecutive cycles a non-empty FIFO head may go un-drained before stall_int fires; at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- int_valid  in  1  integer pipeline presents a write-back this cycle.
- int_rd  in  5  integer write-back destination register.
- int_data  in  32  integer write-back data.
- int_float  in  1  1 = destination is the float bank (mtc1-style), 0 = integer bank.
- fpu_valid  in  1  FPU result available.
- fpu_ready  out  1  FIFO can accept; push occurs on fpu_valid & fpu_ready.
- fpu_rd  in  5  FPU destination register (always float bank).
- fpu_data  in  32  FPU result.
- stall_int  out  1  registered; pipeline must hold and re-present its write-back this cycle.
- writeReg  out  5  register-file write address.
- writeData  out  32  register-file write data.
- regWrite  out  1  register-file write enable.
- float  out  1  register-file bank select.
- fifo_count  out  PTR_W+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - writeReg = 0, writeData = 0, regWrite = 0, float = 0;
  - stall_int = 0, fifo_count = 0;
  - FIFO pointers = 0, wait counter = 0.
- Reset while operating: all buffered FPU results and pending writes are discarded. No write issues in the cycle after reset.
- fpu_ready = !reset && (fifo_count != DEPTH). It is computed from the registered count, so a pop in the same cycle does not free space for a push in that cycle.
- Register-zero filter:
  - an FPU push with fpu_rd == 0 is accepted but not stored, and fifo_count is unchanged;
  - an int write-back with int_rd == 0 is treated as int idle.
- Issue selection, evaluated each cycle and registered at the rising edge:
  - 1. If int_valid && !stall_int && int_rd != 0: issue int. Next cycle regWrite = 1, writeReg = int_rd, writeData = int_data, float = int_float.
  - 2. Else if the FIFO is non-empty: pop the head. Next cycle regWrite = 1, writeReg = head rd, writeData = head data, float = 1.
  - 3. Else: regWrite = 0. writeReg, writeData and float hold their last values.
- Latency:
  - int write-back to the write port: 1 cycle;
  - FPU write-back to the write port: at least 2 cycles (push edge, then pop edge); there is no FIFO bypass.
- Write ordering: FIFO order is preserved. An int write and an FPU write to the same register are ordered by issue slot, not arrival; the hazard unit guarantees no WAW between the two sources.
- Simultaneous push and pop: allowed when not full. fifo_count is unchanged and pointers wrap modulo DEPTH.
- Starvation counter:
  - increments each cycle the FIFO is non-empty and no pop occurs;
  - clears on any pop or when the FIFO is empty.
  - When it equals MAX_WAIT-1 and no pop occurs: stall_int = 1 on the next cycle, for exactly one cycle, and the counter clears.
- While stall_int = 1: int_valid is ignored (rule 1 is suppressed), so the FIFO head is guaranteed to pop. The pipeline re-presents its write-back in the following cycle.
- stall_int never asserts on two consecutive cycles.

Optional Feature:
- Macro: WB_PENDING_MASK_EN.
- Defined:
  - adds output pend_f [31:0];
  - bit r = 1 while any FIFO entry targets float register r;
  - maintained as a per-register count (PTR_W+1 bits), incremented on a stored push and decremented on pop; same-cycle push and pop to the same r leaves it unchanged;
  - reset clears all counts; pend_f[0] is always 0;
  - the hazard unit uses pend_f to stall RAW reads of the float bank.
- Not defined: no pend_f port and no per-register counters; the hazard unit relies on the FPU busy signal instead.

Test Plan:
- Reset then idle, int_valid = 0 and fpu_valid = 0 → regWrite = 0, fifo_count = 0, fpu_ready = 1, stall_int = 0 indefinitely.
- int_valid = 1, int_rd = 5, int_data = 0xDEADBEEF, int_float = 0 for one cycle → next cycle regWrite = 1, writeReg = 5, writeData = 0xDEADBEEF, float = 0.
- FPU pushes rd = 3 (0x3F800000) and rd = 4 (0x40000000) on consecutive cycles with int idle → writes to float 3 then float 4 on cycles t+2 and t+3, float = 1; fifo_count returns to 0.
- Int busy every cycle with rd = 7, and DEPTH+1 FPU pushes attempted → fpu_ready = 0 once fifo_count = 4. After MAX_WAIT = 8 cycles stall_int = 1 for one cycle, the head pops, and the int write resumes the next cycle.
- FPU push with fpu_rd = 0 and int write with int_rd = 0 → no regWrite, fifo_count unchanged.
- Fill FIFO with 3 entries, assert reset for one cycle → fifo_count = 0, regWrite = 0; no stale entry is ever written afterwards.
